// File: rtl/ifetch.sv
// Instruction fetch stage: issues one memory request at a time, holds the
// returned instruction for decode, and honours redirects from control.
// Optional feature: define IFETCH_STALL_EN to add a 'stall' input that
// freezes a presented instruction while stall=1.
module ifetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef IFETCH_STALL_EN
    ,
    input  logic               stall
`endif
);

    // FETCH: request outstanding, HOLD: instruction presented,
    // FLUSH: request outstanding whose data will be thrown away
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0]   target, target_nxt;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [ADDR_W-1:0]   pc_nxt;
    logic                hold_stall;

`ifdef IFETCH_STALL_EN
    assign hold_stall = stall;
`else
    assign hold_stall = 1'b0;
`endif

    // Handshake outputs come from the state; reset masks them immediately
    assign imem_req    = (state != HOLD) && !reset;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state == HOLD) && !reset;
    assign op          = instr[INSTR_W-1 -: 4];

    // Next-state and datapath updates for each fetch situation
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        target_nxt   = target;
        instr_nxt    = instr;
        pc_nxt       = pc;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_nxt = redirect_target;
                    end else begin
                        instr_nxt    = imem_rdata;
                        pc_nxt       = fetch_pc;
                        fetch_pc_nxt = fetch_pc + PC_STEP;
                        state_nxt    = HOLD;
                    end
                end else if (redirect) begin
                    target_nxt = redirect_target;
                    state_nxt  = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    fetch_pc_nxt = redirect ? redirect_target : target;
                    state_nxt    = FETCH;
                end else if (redirect) begin
                    target_nxt = redirect_target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_target;
                    state_nxt    = FETCH;
                end else if (instr_ready && !hold_stall) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= '0;
            target   <= '0;
            instr    <= '0;
            pc       <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            target   <= target_nxt;
            instr    <= instr_nxt;
            pc       <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level reference model.
// Define IFETCH_STALL_EN to exercise the stall input.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [7:0]  pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFETCH_STALL_EN
    logic        stall;
`endif

    int tests_run;
    int tests_failed;

    // Reference model: one request in flight or one instruction held
    bit          m_have;
    bit          m_doomed;
    logic [7:0]  m_addr;
    logic [7:0]  m_pend;
    logic [15:0] m_instr;
    logic [7:0]  m_pc;

    // Outputs sampled in the middle of the most recent cycle
    logic        obs_req;
    logic [7:0]  obs_addr;
    logic        obs_valid;
    logic [15:0] obs_instr;
    logic [3:0]  obs_op;
    logic [7:0]  obs_pc;

    ifetch #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .op              (op),
        .pc              (pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready)
`ifdef IFETCH_STALL_EN
        ,
        .stall           (stall)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance the model
    task automatic applyStimulus(input bit r, input bit a, input logic [15:0] d,
                                 input bit rd, input logic [7:0] t,
                                 input bit rdy, input bit st);
        bit st_eff;
        bit exp_req;
        bit exp_valid;
`ifdef IFETCH_STALL_EN
        st_eff = st;
`else
        st_eff = st & 1'b0;
`endif
        @(negedge clk);
        reset           = r;
        imem_ack        = a;
        imem_rdata      = d;
        redirect        = rd;
        redirect_target = t;
        instr_ready     = rdy;
`ifdef IFETCH_STALL_EN
        stall           = st_eff;
`endif
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_instr = instr;
        obs_op    = op;
        obs_pc    = pc;

        exp_req   = !r && !m_have;
        exp_valid = !r && m_have;
        checkOutput("imem_req", 32'(obs_req), 32'(exp_req));
        checkOutput("instr_valid", 32'(obs_valid), 32'(exp_valid));
        if (exp_req)
            checkOutput("imem_addr", 32'(obs_addr), 32'(m_addr));
        if (!r) begin
            checkOutput("instr", 32'(obs_instr), 32'(m_instr));
            checkOutput("op", 32'(obs_op), 32'(m_instr[15:12]));
            checkOutput("pc", 32'(obs_pc), 32'(m_pc));
        end

        @(posedge clk);
        if (r) begin
            m_have   = 1'b0;
            m_doomed = 1'b0;
            m_addr   = 8'h00;
            m_pend   = 8'h00;
            m_instr  = 16'h0000;
            m_pc     = 8'h00;
        end else if (m_have) begin
            if (rd) begin
                m_have = 1'b0;
                m_addr = t;
            end else if (rdy && !st_eff) begin
                m_have = 1'b0;
            end
        end else if (m_doomed) begin
            if (rd) m_pend = t;
            if (a) begin
                m_addr   = m_pend;
                m_doomed = 1'b0;
            end
        end else if (a) begin
            if (rd) begin
                m_addr = t;
            end else begin
                m_have  = 1'b1;
                m_instr = d;
                m_pc    = m_addr;
                m_addr  = 8'((int'(m_addr) + 1) % 256);
            end
        end else if (rd) begin
            m_doomed = 1'b1;
            m_pend   = t;
        end
    endtask

    // Directed scenarios, then random traffic
    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        m_have          = 1'b0;
        m_doomed        = 1'b0;
        m_addr          = 8'h00;
        m_pend          = 8'h00;
        m_instr         = 16'h0000;
        m_pc            = 8'h00;
        reset           = 1'b1;
        imem_ack        = 1'b0;
        imem_rdata      = 16'h0000;
        redirect        = 1'b0;
        redirect_target = 8'h00;
        instr_ready     = 1'b0;
`ifdef IFETCH_STALL_EN
        stall           = 1'b0;
`endif

        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0, 0);
        checkOutput("rst_valid", 32'(obs_valid), 32'd0);
        checkOutput("rst_req", 32'(obs_req), 32'd0);
        checkOutput("rst_pc", 32'(obs_pc), 32'd0);

        // Back-to-back fetches of 16'h3123 from 0,1,2
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
            checkOutput("seq_addr", 32'(obs_addr), 32'(k));
            applyStimulus(0, 1, 16'h3123, 0, 8'h0, 1, 0);
            applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
            checkOutput("seq_valid", 32'(obs_valid), 32'd1);
            checkOutput("seq_op", 32'(obs_op), 32'h3);
            checkOutput("seq_pc", 32'(obs_pc), 32'(k));
        end

        // Decode not ready for 5 cycles
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0);
        applyStimulus(0, 1, 16'h5A5A, 0, 8'h0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 16'hFFFF, 0, 8'h0, 0, 0);
            checkOutput("hold_req", 32'(obs_req), 32'd0);
            checkOutput("hold_pc", 32'(obs_pc), 32'd3);
            checkOutput("hold_instr", 32'(obs_instr), 32'h5A5A);
        end
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0);
        checkOutput("after_hold_addr", 32'(obs_addr), 32'h4);

        // Redirect to 8'h40 while a request to 8'h05 is waiting
        applyStimulus(0, 1, 16'h2222, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        applyStimulus(0, 0, 16'h0, 1, 8'h40, 1, 0);
        checkOutput("flush_addr0", 32'(obs_addr), 32'h05);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("flush_addr1", 32'(obs_addr), 32'h05);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("flush_addr2", 32'(obs_addr), 32'h05);
        applyStimulus(0, 1, 16'hDEAD, 0, 8'h0, 1, 0);
        checkOutput("flush_addr3", 32'(obs_addr), 32'h05);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("flush_valid", 32'(obs_valid), 32'd0);
        checkOutput("flush_new_addr", 32'(obs_addr), 32'h40);

        // Wrap from 8'hFF to 8'h00
        applyStimulus(0, 1, 16'h9999, 1, 8'hFF, 1, 0);
        applyStimulus(0, 1, 16'hBEEF, 0, 8'h0, 1, 0);
        checkOutput("wrap_addr", 32'(obs_addr), 32'hFF);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("wrap_pc", 32'(obs_pc), 32'hFF);
        checkOutput("wrap_valid", 32'(obs_valid), 32'd1);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0);
        checkOutput("wrap_next_addr", 32'(obs_addr), 32'h00);

        // Reset during an outstanding request with an ack in the reset cycle
        applyStimulus(1, 1, 16'h7777, 0, 8'h0, 0, 0);
        checkOutput("midrst_valid", 32'(obs_valid), 32'd0);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0);
        checkOutput("midrst_req", 32'(obs_req), 32'd1);
        checkOutput("midrst_addr", 32'(obs_addr), 32'h00);
        applyStimulus(0, 1, 16'h1111, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0);
        checkOutput("midrst_pc", 32'(obs_pc), 32'h00);
        checkOutput("midrst_instr", 32'(obs_instr), 32'h1111);

`ifdef IFETCH_STALL_EN
        // Stall overrides ready, redirect still wins
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 1);
            checkOutput("stall_valid", 32'(obs_valid), 32'd1);
            checkOutput("stall_instr", 32'(obs_instr), 32'h1111);
        end
        applyStimulus(0, 0, 16'h0, 1, 8'h10, 1, 1);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("stall_redir_valid", 32'(obs_valid), 32'd0);
        checkOutput("stall_redir_addr", 32'(obs_addr), 32'h10);
`else
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 0);
        checkOutput("drain_addr", 32'(obs_addr), 32'h01);
`endif

        // Random traffic including stray acks, redirects and occasional reset
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 40,
                          16'($urandom),
                          $urandom_range(0, 99) < 15,
                          8'($urandom),
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 30);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
